// File: rtl/qbert_move_ctrl.sv
// Q*bert jump sequencer: buffers player/Nios jump requests and hands them to the
// display/motion layer one at a time, tracking the authoritative one-hot cube position.
module qbert_move_ctrl #(
    parameter int N_ROWS     = 7,
    parameter int COOLDOWN   = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                restart,
    input  logic                                req_pl_valid,
    input  logic [2:0]                          req_pl_dir,
    input  logic                                req_cpu_valid,
    input  logic [2:0]                          req_cpu_dir,
    input  logic                                inhibit,
    input  logic [2:0]                          state_qb,
    input  logic                                done_move_qb,
    output logic [2:0]                          e_jump_qb,
    output logic [N_ROWS*(N_ROWS+1)/2-1:0]      e_next_qb,
    output logic [N_ROWS*(N_ROWS+1)/2-1:0]      position_qb,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                overflow,
    output logic                                fall,
    output logic [15:0]                         jump_cnt
);
    localparam int NC  = N_ROWS * (N_ROWS + 1) / 2;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CDW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [2:0] S_WAIT    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_MOVE    = 3'd2;
    localparam logic [2:0] S_COOL    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    localparam logic [2:0] L_START  = 3'd1;
    localparam logic [2:0] L_JUMP   = 3'd2;
    localparam logic [2:0] L_IDLE   = 3'd3;
    localparam logic [2:0] L_SAUCER = 3'd4;

    localparam logic [NC-1:0] TOP = NC'(1);

    // Target cube for a jump; a target outside the pyramid yields all-zero.
    function automatic logic [NC-1:0] f_target(input logic [NC-1:0] pos, input logic [2:0] dir);
        int nr;
        int nc;
        f_target = '0;
        for (int r = 1; r <= N_ROWS; r++) begin
            for (int c = 1; c <= r; c++) begin
                if (pos[r*(r-1)/2 + c - 1]) begin
                    nr = r;
                    nc = c;
                    case (dir)
                        3'd1:    nr = r + 1;
                        3'd2:    begin nr = r + 1; nc = c + 1; end
                        3'd3:    begin nr = r - 1; nc = c - 1; end
                        3'd4:    nr = r - 1;
                        default: nr = 0;
                    endcase
                    if (nr >= 1 && nr <= N_ROWS && nc >= 1 && nc <= nr)
                        f_target[nr*(nr-1)/2 + nc - 1] = 1'b1;
                end
            end
        end
    endfunction

    logic [2:0]                  r_state;
    logic [FIFO_DEPTH-1:0][2:0]  r_fifo;
    logic [CW-1:0]               r_cnt;
    logic                        r_ovf;
    logic [2:0]                  r_ejump;
    logic [NC-1:0]               r_enext;
    logic [NC-1:0]               r_pos;
    logic                        r_fall;
    logic [15:0]                 r_jcnt;
    logic [CDW-1:0]              r_cool;
    logic                        r_seen_start;

    logic                        w_pl_ok, w_cpu_ok, w_pop, w_drop, w_saucer, w_recover_done, w_layer_ready;
    logic [FIFO_DEPTH-1:0][2:0]  w_q;
    logic [CW-1:0]               w_cnt;

    assign w_pl_ok        = req_pl_valid  && !inhibit && (req_pl_dir  != 3'd0) && (req_pl_dir  <= 3'd4);
    assign w_cpu_ok       = req_cpu_valid && !inhibit && (req_cpu_dir != 3'd0) && (req_cpu_dir <= 3'd4);
    assign w_layer_ready  = (state_qb == L_IDLE) && done_move_qb;
    assign w_pop          = (r_state == S_WAIT) && (r_cnt != '0) && w_layer_ready;
    assign w_saucer       = (state_qb == L_SAUCER) && (r_state != S_RECOVER);
    assign w_recover_done = (r_state == S_RECOVER) && r_seen_start && w_layer_ready;

    // Pop first so a full FIFO can still accept a request in the cycle it issues.
    always_comb begin
        w_q    = r_fifo;
        w_cnt  = r_cnt;
        w_drop = 1'b0;
        if (w_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) w_q[i] = w_q[i+1];
            w_q[FIFO_DEPTH-1] = '0;
            w_cnt = w_cnt - CW'(1);
        end
        if (w_pl_ok) begin
            if (w_cnt < CW'(FIFO_DEPTH)) begin
                w_q[w_cnt] = req_pl_dir;
                w_cnt      = w_cnt + CW'(1);
            end else begin
                w_drop = 1'b1;
            end
        end
        if (w_cpu_ok) begin
            if (w_cnt < CW'(FIFO_DEPTH)) begin
                w_q[w_cnt] = req_cpu_dir;
                w_cnt      = w_cnt + CW'(1);
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_state      <= S_WAIT;
            r_fifo       <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_ejump      <= 3'd0;
            r_enext      <= TOP;
            r_pos        <= TOP;
            r_fall       <= 1'b0;
            r_cool       <= '0;
            r_seen_start <= 1'b0;
            if (reset) r_jcnt <= '0;
        end else begin
            r_fall <= 1'b0;
            r_ovf  <= r_ovf | w_drop;
            if (w_recover_done) begin
                r_fifo <= '0;
                r_cnt  <= '0;
            end else begin
                r_fifo <= w_q;
                r_cnt  <= w_cnt;
            end
            if (w_saucer) begin
                r_state      <= S_RECOVER;
                r_ejump      <= 3'd0;
                r_seen_start <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT: if (w_pop) begin
                        r_enext <= f_target(r_pos, r_fifo[0]);
                        r_ejump <= r_fifo[0];
                        r_state <= S_ISSUE;
                    end
                    S_ISSUE: if (state_qb == L_JUMP) begin
                        r_ejump <= 3'd0;
                        r_state <= S_MOVE;
                    end else if (state_qb != L_IDLE) begin
                        r_ejump      <= 3'd0;
                        r_seen_start <= (state_qb == L_START);
                        r_state      <= S_RECOVER;
                    end
                    S_MOVE: if (w_layer_ready) begin
                        r_pos <= r_enext;
                        if (r_enext == '0) begin
                            r_fall       <= 1'b1;
                            r_seen_start <= 1'b0;
                            r_state      <= S_RECOVER;
                        end else begin
                            if (r_jcnt != 16'hFFFF) r_jcnt <= r_jcnt + 16'd1;
                            r_cool  <= CDW'(COOLDOWN - 1);
                            r_state <= S_COOL;
                        end
                    end
                    S_COOL: if (r_cool == '0) r_state <= S_WAIT;
                            else              r_cool  <= r_cool - CDW'(1);
                    S_RECOVER: begin
                        if (state_qb == L_START) r_seen_start <= 1'b1;
                        if (w_recover_done) begin
                            r_pos   <= TOP;
                            r_enext <= TOP;
                            r_cool  <= CDW'(COOLDOWN - 1);
                            r_state <= S_COOL;
                        end
                    end
                    default: r_state <= S_WAIT;
                endcase
            end
        end
    end

    assign e_jump_qb   = r_ejump;
    assign e_next_qb   = r_enext;
    assign position_qb = r_pos;
    assign fifo_count  = r_cnt;
    assign overflow    = r_ovf;
    assign fall        = r_fall;
    assign jump_cnt    = r_jcnt;
endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Scoreboard bench for qbert_move_ctrl: expected jumps queued at request time,
// compared when the controller presents them to the (bench-modelled) layer.
module tb_qbert_move_ctrl;
    logic        clk = 1'b0;
    logic        reset, restart, req_pl_valid, req_cpu_valid, inhibit, done_move_qb;
    logic [2:0]  req_pl_dir, req_cpu_dir, state_qb;
    logic [2:0]  e_jump_qb;
    logic [27:0] e_next_qb, position_qb;
    logic [1:0]  fifo_count;
    logic        overflow, fall;
    logic [15:0] jump_cnt;

    qbert_move_ctrl dut (
        .clk(clk), .reset(reset), .restart(restart),
        .req_pl_valid(req_pl_valid), .req_pl_dir(req_pl_dir),
        .req_cpu_valid(req_cpu_valid), .req_cpu_dir(req_cpu_dir),
        .inhibit(inhibit), .state_qb(state_qb), .done_move_qb(done_move_qb),
        .e_jump_qb(e_jump_qb), .e_next_qb(e_next_qb), .position_qb(position_qb),
        .fifo_count(fifo_count), .overflow(overflow), .fall(fall), .jump_cnt(jump_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  dir;
        logic [27:0] nxt;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          m_tail   = 1;
    logic [27:0] m_last_next;
    logic [15:0] m_jcnt   = 0;

    function automatic logic [27:0] oh(input int idx);
        logic [27:0] one;
        one = 28'h1;
        if (idx < 1) return 28'h0;
        return one << (idx - 1);
    endfunction

    function automatic int tb_next(input int idx, input int dir);
        int r, base, c, nr, nc;
        if (idx < 1) return 0;
        r = 1; base = 0;
        while (idx > base + r) begin base += r; r++; end
        c = idx - base;
        case (dir)
            1: begin nr = r + 1; nc = c;     end
            2: begin nr = r + 1; nc = c + 1; end
            3: begin nr = r - 1; nc = c - 1; end
            4: begin nr = r - 1; nc = c;     end
            default: return 0;
        endcase
        if (nr < 1 || nr > 7 || nc < 1 || nc > nr) return 0;
        return nr * (nr - 1) / 2 + nc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int dir);
        exp_t e;
        m_tail = tb_next(m_tail, dir);
        e.dir  = 3'(dir);
        e.nxt  = oh(m_tail);
        sb.push_back(e);
    endtask

    task automatic req(input bit cpu, input int dir);
        if (cpu) begin req_cpu_valid = 1'b1; req_cpu_dir = 3'(dir); end
        else     begin req_pl_valid  = 1'b1; req_pl_dir  = 3'(dir); end
        push_exp(dir);
        tick();
        req_pl_valid = 1'b0; req_cpu_valid = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (e_jump_qb == 3'd0 && n < 60) begin tick(); n++; end
        checks++;
        if (e_jump_qb == 3'd0) begin
            failures++;
            $display("FAIL %s issue_timeout: e_jump_qb stayed 0 for %0d cycles", tag, n);
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard_empty", tag);
        end else begin
            e = sb.pop_front();
            m_last_next = e.nxt;
            checks++;
            if (e_jump_qb !== e.dir) begin
                failures++;
                $display("FAIL %s e_jump_qb: got %0d want %0d", tag, e_jump_qb, e.dir);
            end
            checks++;
            if (e_next_qb !== e.nxt) begin
                failures++;
                $display("FAIL %s e_next_qb: got %h want %h", tag, e_next_qb, e.nxt);
            end
        end
    endtask

    task automatic complete_move(input string tag);
        bit exp_fall;
        exp_fall = (m_last_next == 28'h0);
        state_qb = 3'd2; done_move_qb = 1'b0;
        tick();
        checks++;
        if (e_jump_qb !== 3'd0) begin
            failures++;
            $display("FAIL %s jump_clear: e_jump_qb got %0d want 0", tag, e_jump_qb);
        end
        state_qb = 3'd3; done_move_qb = 1'b1;
        tick();
        if (!exp_fall) m_jcnt++;
        checks++;
        if (position_qb !== m_last_next || fall !== exp_fall || jump_cnt !== m_jcnt) begin
            failures++;
            $display("FAIL %s move_done: pos=%h fall=%0b cnt=%0d want pos=%h fall=%0b cnt=%0d",
                     tag, position_qb, fall, jump_cnt, m_last_next, exp_fall, m_jcnt);
        end
        tick();
        checks++;
        if (fall !== 1'b0 || position_qb !== m_last_next) begin
            failures++;
            $display("FAIL %s after_move: fall=%0b pos=%h want fall=0 pos=%h", tag, fall, position_qb, m_last_next);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1; tick(); restart = 1'b0;
        m_tail = 1; sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick();
        checks++;
        if (e_jump_qb !== 3'd0 || e_next_qb !== 28'h1 || position_qb !== 28'h1 || fifo_count !== 2'd0 ||
            overflow !== 1'b0 || fall !== 1'b0 || jump_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: jump=%0d next=%h pos=%h cnt=%0d ovf=%0b fall=%0b jc=%0d",
                     e_jump_qb, e_next_qb, position_qb, fifo_count, overflow, fall, jump_cnt);
        end
        reset = 1'b0; tick();
        m_tail = 1; m_jcnt = 0;
    endtask

    task automatic test_single_jump();
        req(1'b0, 2);
        checks++;
        if (e_jump_qb !== 3'd0 || fifo_count !== 2'd1) begin
            failures++;
            $display("FAIL latency_1: jump=%0d cnt=%0d want 0/1", e_jump_qb, fifo_count);
        end
        tick();
        checks++;
        if (e_jump_qb !== 3'd2) begin
            failures++;
            $display("FAIL latency_2: e_jump_qb got %0d want 2", e_jump_qb);
        end
        wait_issue("single");
        repeat (3) tick();
        checks++;
        if (e_jump_qb !== 3'd2 || e_next_qb !== 28'h4) begin
            failures++;
            $display("FAIL hold: jump=%0d next=%h want 2/4", e_jump_qb, e_next_qb);
        end
        complete_move("single");
    endtask

    task automatic test_back_to_back();
        req(1'b0, 1);
        wait_issue("to_cube5");
        complete_move("to_cube5");
        repeat (20) tick();
        req_pl_valid = 1'b1;  req_pl_dir  = 3'd1;
        req_cpu_valid = 1'b1; req_cpu_dir = 3'd4;
        push_exp(1); push_exp(4);
        tick();
        req_pl_valid = 1'b0; req_cpu_valid = 1'b0;
        checks++;
        if (fifo_count !== 2'd2) begin
            failures++;
            $display("FAIL b2b_count2: got %0d want 2", fifo_count);
        end
        tick();
        checks++;
        if (fifo_count !== 2'd1) begin
            failures++;
            $display("FAIL b2b_count1: got %0d want 1", fifo_count);
        end
        wait_issue("b2b_first");
        complete_move("b2b_first");
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (e_jump_qb !== 3'd0) begin
                failures++;
                $display("FAIL cooldown: issued early at cycle %0d jump=%0d", i, e_jump_qb);
            end
            tick();
        end
        wait_issue("b2b_second");
        checks++;
        if (fifo_count !== 2'd0) begin
            failures++;
            $display("FAIL b2b_count0: got %0d want 0", fifo_count);
        end
        complete_move("b2b_second");
    endtask

    task automatic test_fall();
        repeat (20) tick();
        do_restart();
        checks++;
        if (position_qb !== 28'h1 || e_next_qb !== 28'h1 || jump_cnt !== m_jcnt) begin
            failures++;
            $display("FAIL restart_keep: pos=%h next=%h jc=%0d want 1/1/%0d", position_qb, e_next_qb, jump_cnt, m_jcnt);
        end
        req(1'b1, 3);
        wait_issue("fall");
        complete_move("fall");
        state_qb = 3'd1; done_move_qb = 1'b0; tick();
        state_qb = 3'd3; done_move_qb = 1'b1; tick();
        checks++;
        if (position_qb !== 28'h1 || e_next_qb !== 28'h1) begin
            failures++;
            $display("FAIL respawn: pos=%h next=%h want 1/1", position_qb, e_next_qb);
        end
        m_tail = 1;
    endtask

    task automatic test_overflow();
        state_qb = 3'd2; done_move_qb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_pl_valid = 1'b1; req_pl_dir = 3'd1; tick();
        end
        req_pl_valid = 1'b0;
        checks++;
        if (fifo_count !== 2'd2 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow: cnt=%0d ovf=%0b want 2/1", fifo_count, overflow);
        end
        do_restart();
        checks++;
        if (fifo_count !== 2'd0 || overflow !== 1'b0 || position_qb !== 28'h1) begin
            failures++;
            $display("FAIL overflow_restart: cnt=%0d ovf=%0b pos=%h want 0/0/1", fifo_count, overflow, position_qb);
        end
        state_qb = 3'd3; done_move_qb = 1'b1;
    endtask

    task automatic test_edge_and_filter();
        for (int k = 0; k < 6; k++) begin
            req(1'b0, 1);
            wait_issue("descend");
            complete_move("descend");
        end
        checks++;
        if (position_qb !== 28'h200000) begin
            failures++;
            $display("FAIL cube22: pos=%h want 200000", position_qb);
        end
        req(1'b0, 1);
        wait_issue("off_right_edge");
        do_restart();
        repeat (3) tick();
        req_pl_valid = 1'b1; req_pl_dir = 3'd6;
        req_cpu_valid = 1'b1; req_cpu_dir = 3'd0;
        tick();
        req_cpu_valid = 1'b0;
        inhibit = 1'b1; req_pl_dir = 3'd1;
        tick();
        req_pl_valid = 1'b0; inhibit = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (fifo_count !== 2'd0 || e_jump_qb !== 3'd0) begin
                failures++;
                $display("FAIL filter: cnt=%0d jump=%0d want 0/0", fifo_count, e_jump_qb);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        req(1'b0, 2);
        wait_issue("pre_reset");
        state_qb = 3'd2; done_move_qb = 1'b0; tick();
        reset = 1'b1; tick();
        reset = 1'b0; state_qb = 3'd3; done_move_qb = 1'b1;
        m_tail = 1; m_jcnt = 0; sb.delete();
        checks++;
        if (e_jump_qb !== 3'd0 || position_qb !== 28'h1 || jump_cnt !== 16'd0 || fifo_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_move: jump=%0d pos=%h jc=%0d cnt=%0d", e_jump_qb, position_qb, jump_cnt, fifo_count);
        end
        req(1'b0, 2);
        tick();
        checks++;
        if (e_jump_qb !== 3'd2) begin
            failures++;
            $display("FAIL post_reset_wait: e_jump_qb got %0d want 2", e_jump_qb);
        end
        wait_issue("post_reset");
        complete_move("post_reset");
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; inhibit = 1'b0;
        req_pl_valid = 1'b0; req_pl_dir = 3'd0; req_cpu_valid = 1'b0; req_cpu_dir = 3'd0;
        state_qb = 3'd3; done_move_qb = 1'b1;
        m_last_next = 28'h1;
        test_reset();
        test_single_jump();
        test_back_to_back();
        test_fall();
        test_overflow();
        test_edge_and_filter();
        test_reset_mid_move();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
